vga_sync_gen: RTL
=================

Name: vga_sync_gen

Overview:
Raster timing generator for the 640x480@60 Hz VGA output, clocked directly by the divided ~25 MHz pixel clock from the VGA clock divider. Produces horizontal/vertical counters, hsync/vsync, a display-enable window and a frame-start strobe. Downstream pixel/colour logic (board renderer) consumes these. The `enable` input lets the block run on a faster clock with a pixel strobe instead of the divided clock.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, sync asserted level (0 = active-low, 1 = active-high); applies to both hsync and vsync

Ports:
clock  input  1  pixel clock; rising-edge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  pixel advance strobe; tie high when clocked by the divided pixel clock
h_count  output  10  current pixel column, 0..H_TOTAL-1
v_count  output  10  current line, 0..V_TOTAL-1
hsync  output  1  horizontal sync, level per SYNC_POL
vsync  output  1  vertical sync, level per SYNC_POL
display_en  output  1  high while (h_count, v_count) is inside the visible area
frame_start  output  1  one-clock pulse when counters enter (0,0)

Behaviour:
- H_TOTAL = sum of H_* (800 by default); V_TOTAL = sum of V_* (525 by default). Both must be ≤ 1024; there is no check in RTL.
- All outputs are registered. hsync, vsync and display_en always describe the current h_count/v_count, with zero skew.
- Reset (reset_n low, asynchronous) sets:
  - h_count = H_TOTAL-1 and v_count = V_TOTAL-1;
  - hsync and vsync inactive (= ~SYNC_POL);
  - display_en = 0 and frame_start = 0.
  These values are consistent with the decode at that position.
- Rising edge with enable = 1:
  - h_count increments. At H_TOTAL-1 it wraps to 0 and v_count advances.
  - v_count advances by 1 and wraps from V_TOTAL-1 to 0.
- Rising edge with enable = 0: all counters and decoded outputs hold. frame_start is cleared to 0.
- First enabled edge after reset yields (0,0) with display_en = 1 and frame_start = 1. This gives zero-latency frame alignment.
- hsync is active iff h_count is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. [656, 751] by default.
- vsync is active iff v_count is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. [490, 491] by default. It is line-based and changes only when h_count wraps to 0.
- display_en = (h_count < H_VISIBLE) && (v_count < V_VISIBLE).
- frame_start is 1 for exactly one clock, on the edge where counters become (0,0). It is never asserted at any other time.
- Decode is computed from next-state counter values so that the registered outputs stay aligned.
- Reset asserted mid-frame: outputs go to reset values immediately, with no partial-line completion.
- The frame period is H_TOTAL*V_TOTAL enabled cycles (420 000 by default).

Optional Feature:
Macro VGA_SYNC_FRAME_COUNT_EN.
- Defined: adds output frame_count [15:0]. It is reset to 0 and increments, wrapping 0xFFFF→0, on every edge that asserts frame_start. The game logic uses it for a frame-based tick (gravity timer).
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants (H_/V_ visible, front, sync, back);
  - derived H_TOTAL and V_TOTAL;
  - COUNT_W = 10.
- Natural sub-module vga_axis_counter, instantiated twice (horizontal and vertical), containing:
  - a wrapping counter with advance input, reset-to-TOTAL-1 and wrap output;
  - sync-window and visible-window decode.
  The vertical instance advances on the horizontal wrap gated by enable.

Test Plan:
- Reset then enable=1 constantly → first edge (0,0), display_en=1, frame_start=1. Next edge frame_start=0, h_count=1.
- Run one line → hsync active (0) exactly for h_count 656..751 (96 clocks). display_en falls at h_count=640. h wraps 799→0 and v_count increments.
- Run a full frame → vsync low only on lines 490–491 (1600 clocks). frame_start pulses again exactly 420 000 clocks after the first.
- enable toggled 1-of-4 cycles → counters advance only on enabled edges. frame_start is a single-clock pulse, and the period is 1 680 000 clocks.
- Assert reset_n low asynchronously at (300,200) mid-frame → outputs immediately (799,524), sync inactive, display_en=0. Restart at (0,0) on the next enabled edge.
- SYNC_POL=1 with VGA_SYNC_FRAME_COUNT_EN defined → sync pulses high in the same windows. frame_count reads 3 after the third frame_start.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants and helpers for the VGA sync generator.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package vga_timing_pkg;

    // Width of the raster counters. Both axis totals must fit in this width.
    localparam int COUNT_W = 10;

    // Default 640x480@60 timing, in pixels (horizontal) and lines (vertical).
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Narrow an integer timing constant to counter width.
    function automatic logic [COUNT_W-1:0] to_cnt(input int value);
        return value[COUNT_W-1:0];
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus registered sync window and next-state visible flag.
// Latency: count and sync are registered, updated on the advancing edge; wrap_o and visible_next_o are combinational.
// Backpressure: none; advance_i low holds the counter and sync output.
//
// Ports:
//   clock_i, reset_n_i : pixel clock, async active-low reset (count -> TOTAL-1, sync inactive)
//   advance_i          : step the counter on this edge
//   count_o            : current position 0..TOTAL-1
//   wrap_o             : this edge takes the counter from TOTAL-1 back to 0
//   sync_o             : sync level for count_o (asserted level = SYNC_POL)
//   visible_next_o     : position after this edge lies in [0, VISIBLE-1]
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = H_TOTAL,
    parameter int VISIBLE    = DEF_H_VISIBLE,
    parameter int SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT,
    parameter int SYNC_LEN   = DEF_H_SYNC,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic               clock_i,
    input  logic               reset_n_i,
    input  logic               advance_i,
    output logic [COUNT_W-1:0] count_o,
    output logic               wrap_o,
    output logic               sync_o,
    output logic               visible_next_o
);

    localparam logic [COUNT_W-1:0] LAST    = to_cnt(TOTAL - 1);
    localparam logic [COUNT_W-1:0] SYNC_LO = to_cnt(SYNC_START);
    localparam logic [COUNT_W-1:0] SYNC_HI = to_cnt(SYNC_START + SYNC_LEN - 1);
    localparam logic [COUNT_W-1:0] VIS_END = to_cnt(VISIBLE);
    localparam logic [COUNT_W-1:0] ONE     = to_cnt(1);

    logic [COUNT_W-1:0] count_q, count_d;
    logic               sync_q, sync_d;
    logic               at_last;

    assign at_last = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (advance_i) begin
            count_d = at_last ? '0 : (count_q + ONE);
        end
    end

    // Decode from the next-state count so the registered sync lines up with
    // the registered count with no skew.
    always_comb begin
        sync_d = !SYNC_POL;
        if ((count_d >= SYNC_LO) && (count_d <= SYNC_HI)) begin
            sync_d = SYNC_POL;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= LAST;
            sync_q  <= !SYNC_POL;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
        end
    end

    assign count_o        = count_q;
    assign sync_o         = sync_q;
    assign wrap_o         = advance_i && at_last;
    assign visible_next_o = (count_d < VIS_END);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: h/v counters, hsync/vsync, display enable and frame-start strobe.
// Latency: all outputs registered and mutually aligned; first enabled edge after reset lands on (0,0).
// Backpressure: enable low holds counters and decodes; frame_start drops to 0 on any non-advancing edge.
//
// Ports:
//   clock, reset_n      : pixel (or faster) clock, async active-low reset (counters -> last position)
//   enable              : pixel advance strobe; tie high when clocked by the divided pixel clock
//   h_count, v_count    : current column / line
//   hsync, vsync        : sync outputs, asserted level = SYNC_POL
//   display_en          : current position inside the visible area
//   frame_start         : one-clock pulse on the edge that enters (0,0)
//   frame_count         : frames started since reset, wraps at 16 bits
//                         (present only when VGA_SYNC_FRAME_COUNT_EN is defined)
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    output logic [COUNT_W-1:0] h_count,
    output logic [COUNT_W-1:0] v_count,
    output logic               hsync,
    output logic               vsync,
    output logic               display_en,
`ifdef VGA_SYNC_FRAME_COUNT_EN
    output logic [15:0]        frame_count,
`endif
    output logic               frame_start
);

    localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    logic h_wrap, v_wrap;
    logic h_vis_d, v_vis_d;
    logic display_en_q, display_en_d;
    logic frame_start_q, frame_start_d;

    vga_axis_counter #(
        .TOTAL      (H_TOT),
        .VISIBLE    (H_VISIBLE),
        .SYNC_START (H_VISIBLE + H_FRONT),
        .SYNC_LEN   (H_SYNC),
        .SYNC_POL   (SYNC_POL)
    ) u_h_axis (
        .clock_i        (clock),
        .reset_n_i      (reset_n),
        .advance_i      (enable),
        .count_o        (h_count),
        .wrap_o         (h_wrap),
        .sync_o         (hsync),
        .visible_next_o (h_vis_d)
    );

    // h_wrap already includes enable, so the line counter only moves on an
    // enabled edge that ends a line; vsync therefore changes only at h = 0.
    vga_axis_counter #(
        .TOTAL      (V_TOT),
        .VISIBLE    (V_VISIBLE),
        .SYNC_START (V_VISIBLE + V_FRONT),
        .SYNC_LEN   (V_SYNC),
        .SYNC_POL   (SYNC_POL)
    ) u_v_axis (
        .clock_i        (clock),
        .reset_n_i      (reset_n),
        .advance_i      (h_wrap),
        .count_o        (v_count),
        .wrap_o         (v_wrap),
        .sync_o         (vsync),
        .visible_next_o (v_vis_d)
    );

    // Both visible flags are next-state, so a disabled edge reproduces the
    // current value and display_en holds.
    assign display_en_d  = h_vis_d && v_vis_d;
    // The vertical wrap only fires on the edge that takes (last,last) to (0,0).
    assign frame_start_d = v_wrap;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            display_en_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            display_en_q  <= display_en_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign display_en  = display_en_q;
    assign frame_start = frame_start_q;

`ifdef VGA_SYNC_FRAME_COUNT_EN
    logic [15:0] frame_count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_count_q <= '0;
        end else if (frame_start_d) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign frame_count = frame_count_q;
`endif

endmodule
